// File: rtl/alu_result_display.sv
// ALU result display: captures an 8-bit unsigned result plus an overflow flag,
// converts it to BCD with a sequential double-dabble, and drives a 4-digit
// multiplexed active-low 7-segment display (overflow 'E' on the left digit).
module alu_result_display #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] value,
    input  logic       overflow,
    output logic       busy,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        UPDATE
    } state_t;

    state_t      state;
    logic [2:0]  step_cnt;
    logic [7:0]  shift_reg;
    logic [11:0] bcd;
    logic [11:0] bcd_adj;
    logic        flag;

    logic [3:0]  hundreds;
    logic [3:0]  tens;
    logic [3:0]  ones;
    logic        ovf_disp;

    logic [CW-1:0] refresh_cnt;
    logic [1:0]    digit_idx;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = 7'b1111111;
        endcase
        return code;
    endfunction

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM: capture on load, 8 shift steps, then publish to the display registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            step_cnt  <= '0;
            shift_reg <= '0;
            bcd       <= '0;
            flag      <= 1'b0;
            hundreds  <= '0;
            tens      <= '0;
            ones      <= '0;
            ovf_disp  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        shift_reg <= value;
                        flag      <= overflow;
                        bcd       <= '0;
                        step_cnt  <= '0;
                        busy      <= 1'b1;
                        state     <= CONV;
                    end
                end
                CONV: begin
                    {bcd, shift_reg} <= {bcd_adj, shift_reg} << 1;
                    step_cnt         <= step_cnt + 3'd1;
                    if (step_cnt == 3'd7) begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    hundreds <= bcd[11:8];
                    tens     <= bcd[7:4];
                    ones     <= bcd[3:0];
                    ovf_disp <= flag;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Select the enable and segment pattern for the digit currently being scanned
    always_comb begin
        an_next  = ~(4'b0001 << digit_idx);
        seg_next = 7'b1111111;
        case (digit_idx)
            2'd0: seg_next = seg_encode(ones);
            2'd1: begin
                if (!(hundreds == 4'd0 && tens == 4'd0)) begin
                    seg_next = seg_encode(tens);
                end
            end
            2'd2: begin
                if (hundreds != 4'd0) begin
                    seg_next = seg_encode(hundreds);
                end
            end
            default: begin
                if (ovf_disp) begin
                    seg_next = 7'b0000110;
                end
            end
        endcase
    end

    // Free-running scan: refresh divider, digit index, and registered an/seg pair
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            an          <= '1;
            seg         <= '1;
        end else begin
            if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_alu_result_display.sv
// Self-checking bench for alu_result_display with a behavioural display model.
module tb_alu_result_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] value = '0;
    logic       overflow = 1'b0;
    logic       busy;
    logic [3:0] an;
    logic [6:0] seg;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    int n_since = 0;
    int busy_left = 0;
    int pv = 0;
    int po = 0;
    int mh = 0, mt = 0, mo = 0, movf = 0;

    alu_result_display #(.REFRESH_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .value    (value),
        .overflow (overflow),
        .busy     (busy),
        .an       (an),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int digit_code(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int model_seg(input int idx);
        case (idx)
            0: return digit_code(mo);
            1: return (mh == 0 && mt == 0) ? 7'b1111111 : digit_code(mt);
            2: return (mh == 0) ? 7'b1111111 : digit_code(mh);
            default: return (movf != 0) ? 7'b0000110 : 7'b1111111;
        endcase
    endfunction

    // Reference model and per-cycle compare
    always @(posedge clk) begin
        int r, l, v, o, idx, ea, es, eb, chk_scan;
        r = int'(rst); l = int'(load); v = int'(value); o = int'(overflow);
        ea = 0; es = 0; chk_scan = 0;
        if (r != 0) begin
            busy_left = 0;
            mh = 0; mt = 0; mo = 0; movf = 0;
            n_since = 0;
        end else begin
            n_since++;
            idx = ((n_since - 1) / DIV) % 4;
            ea = (~(1 << idx)) & 4'hf;
            es = model_seg(idx);
            chk_scan = 1;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    mh = pv / 100;
                    mt = (pv / 10) % 10;
                    mo = pv % 10;
                    movf = po;
                end
            end else if (l != 0) begin
                busy_left = 9;
                pv = v;
                po = o;
            end
        end
        eb = (busy_left > 0) ? 1 : 0;
        #1;
        check("busy", int'(busy), eb);
        if (chk_scan != 0) begin
            check("an", int'(an), ea);
            check("seg", int'(seg), es);
        end
    end

    task automatic do_load(input int v, input int o);
        @(negedge clk);
        load = 1'b1;
        value = 8'(v);
        overflow = o[0];
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 30) begin
            cnt++;
            @(negedge clk);
        end
        if (cnt >= 30) check("busy_timeout", cnt, 0);
    endtask

    // Scan a full refresh period and compare each digit against literal codes
    task automatic show_digits(input string name, input int e3, input int e2,
                               input int e1, input int e0);
        int cap[4];
        for (int i = 0; i < 4; i++) cap[i] = -1;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            case (an)
                4'b1110: cap[0] = int'(seg);
                4'b1101: cap[1] = int'(seg);
                4'b1011: cap[2] = int'(seg);
                4'b0111: cap[3] = int'(seg);
                default: ;
            endcase
            @(negedge clk);
        end
        check({name, "_d3"}, cap[3], e3);
        check({name, "_d2"}, cap[2], e2);
        check({name, "_d1"}, cap[1], e1);
        check({name, "_d0"}, cap[0], e0);
    endtask

    localparam int BL = 7'b1111111;

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (16) @(negedge clk);
        show_digits("reset", BL, BL, BL, 7'b1000000);

        do_load(255, 0);
        wait_idle(cnt);
        check("busy_len_255", cnt, 9);
        check("model_255_h", mh, 2);
        check("model_255_t", mt, 5);
        check("model_255_o", mo, 5);
        show_digits("v255", BL, 7'b0100100, 7'b0010010, 7'b0010010);

        do_load(7, 1);
        wait_idle(cnt);
        show_digits("v7ovf", 7'b0000110, BL, BL, 7'b1111000);

        do_load(100, 0);
        repeat (2) @(negedge clk);
        do_load(5, 0);
        wait_idle(cnt);
        show_digits("v100", BL, 7'b1111001, 7'b1000000, 7'b1000000);

        do_load(42, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("busy_after_abort", int'(busy), 0);
        show_digits("abort", BL, BL, BL, 7'b1000000);
        do_load(42, 0);
        wait_idle(cnt);
        check("busy_len_42", cnt, 9);
        show_digits("v42", BL, BL, 7'b0011001, 7'b0100100);

        do_load(7, 1);
        wait_idle(cnt);
        do_load(0, 0);
        wait_idle(cnt);
        show_digits("v0", BL, BL, BL, 7'b1000000);

        // back-to-back: load right after UPDATE must be accepted
        do_load(9, 0);
        wait_idle(cnt);
        load = 1'b1; value = 8'd123; overflow = 1'b0;
        @(negedge clk);
        load = 1'b0;
        check("b2b_busy", int'(busy), 1);
        wait_idle(cnt);
        show_digits("v123", BL, 7'b1111001, 7'b0100100, 7'b0110000);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            load = ($urandom_range(0, 5) == 0);
            value = 8'($urandom);
            overflow = 1'($urandom);
            rst = ($urandom_range(0, 79) == 0);
        end
        @(negedge clk);
        load = 1'b0;
        rst = 1'b0;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
